dram_arbiter: RTL and testbench

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter.sv | 149 ++++++++++++++
 tb/tb_dram_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Two-requester (cpu, io) round-robin arbiter in front of a single-port
//   data memory. Each granted transaction takes one IDLE cycle to arbitrate,
//   LAT ACCESS cycles with the memory strobed, then one DONE cycle in which
//   the granted requester's Ready pulses.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   cpuReq/cpuWe/cpuAddr/cpuWdata      cpu request side
//   cpuReady/cpuRdata                  cpu completion pulse and read data
//   ioReq/ioWe/ioAddr/ioWdata          io-port request side
//   ioReady/ioRdata                    io completion pulse and read data
//   memEn/memWriteEnable               memory access / write strobes
//   memAddr/memWdata/memRdata          memory address, write data, read data
//   dbg_state                          current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Handshake: a requester raises Req with We/Addr/Wdata and holds all four
// stable until it sees its Ready high for one cycle; Ready is a single-cycle
// pulse and rdata is valid while it is high. There is no backpressure on the
// Ready side. If Req is dropped mid-access the access still finishes and the
// Ready pulse still appears; the requester simply ignores it.

module dram_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpuReq,
  input  logic          cpuWe,
  input  logic [AW-1:0] cpuAddr,
  input  logic [DW-1:0] cpuWdata,
  output logic          cpuReady,
  output logic [DW-1:0] cpuRdata,
  input  logic          ioReq,
  input  logic          ioWe,
  input  logic [AW-1:0] ioAddr,
  input  logic [DW-1:0] ioWdata,
  output logic          ioReady,
  output logic [DW-1:0] ioRdata,
  output logic          memEn,
  output logic          memWriteEnable,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memWdata,
  input  logic [DW-1:0] memRdata,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAT_L = 3'(LAT);

  state_t        state;
  logic [2:0]    cnt;
  logic          grant;       // 0 = cpu, 1 = io
  logic          last_grant;  // resets to io so cpu wins the first tie
  logic          mem_en_q;
  logic          cpu_ready_q;
  logic          io_ready_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] io_rdata_q;

  logic          pick;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic          last_cycle;

  // Round-robin: a lone requester always wins, a tie goes to whoever was
  // not granted last.
  always_comb begin
    pick = ioReq;
    if (cpuReq && ioReq) pick = ~last_grant;
  end

  // Granted requester's inputs are used live; they are required to be stable.
  assign g_we       = grant ? ioWe    : cpuWe;
  assign g_addr     = grant ? ioAddr  : cpuAddr;
  assign g_wdata    = grant ? ioWdata : cpuWdata;
  assign last_cycle = (state == ACCESS) && (cnt == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      mem_en_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      io_ready_q  <= 1'b0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      io_ready_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpuReq || ioReq) begin
            grant      <= pick;
            last_grant <= pick;
            cnt        <= LAT_L;
            mem_en_q   <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt - 3'd1;
          if (last_cycle) begin
            if (!g_we) begin
              if (grant) io_rdata_q  <= memRdata;
              else       cpu_rdata_q <= memRdata;
            end
            // Ready is registered so it lines up exactly with DONE.
            cpu_ready_q <= ~grant;
            io_ready_q  <= grant;
            mem_en_q    <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          mem_en_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // mem_en_q is a reset flop, so every memory strobe drops the moment
  // rst_n falls; address and data are gated by it to stay 0 outside ACCESS.
  assign memEn          = mem_en_q;
  assign memWriteEnable = mem_en_q & g_we;
  assign memAddr        = mem_en_q ? g_addr  : '0;
  assign memWdata       = mem_en_q ? g_wdata : '0;

  assign cpuReady  = cpu_ready_q;
  assign ioReady   = io_ready_q;
  assign cpuRdata  = cpu_rdata_q;
  assign ioRdata   = io_rdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
//   Directed bench for dram_arbiter (AW=8, DW=16, LAT=2). The memory is a
//   pure function of the address. Completions are checked against an
//   expected queue of {who, rdata} entries pushed when requests are driven.

module tb_dram_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          cpuReq, cpuWe, ioReq, ioWe;
  logic [AW-1:0] cpuAddr, ioAddr;
  logic [DW-1:0] cpuWdata, ioWdata;
  logic          cpuReady, ioReady;
  logic [DW-1:0] cpuRdata, ioRdata;
  logic          memEn, memWriteEnable;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata, memRdata;
  logic [1:0]    dbg_state;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] exp_cpu_rd, exp_io_rd;

  dram_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuReady(cpuReady), .cpuRdata(cpuRdata),
    .ioReq(ioReq), .ioWe(ioWe), .ioAddr(ioAddr), .ioWdata(ioWdata),
    .ioReady(ioReady), .ioRdata(ioRdata),
    .memEn(memEn), .memWriteEnable(memWriteEnable),
    .memAddr(memAddr), .memWdata(memWdata), .memRdata(memRdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {~a, a};
  endfunction

  assign memRdata = mem_val(memAddr);

  // ---------------- check helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic who, input logic [AW-1:0] a, input logic we);
    if (!we) begin
      if (who) exp_io_rd  = mem_val(a);
      else     exp_cpu_rd = mem_val(a);
    end
    exp_q.push_back({who, who ? exp_io_rd : exp_cpu_rd});
  endtask

  task automatic sb_pop(input logic who, input logic [DW-1:0] rd);
    logic [DW:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_unexpected: observed ready who=%0d rdata %0h expected no completion", who, rd);
    end else begin
      e = exp_q.pop_front();
      check("sb_completion", {15'd0, who, rd}, {15'd0, e});
    end
  endtask

  // ---------------- completion monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_excl", {31'd0, cpuReady & ioReady}, 32'd0);
      if (cpuReady) sb_pop(1'b0, cpuRdata);
      if (ioReady)  sb_pop(1'b1, ioRdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0;
    ioReq  = 0; ioWe  = 0; ioAddr  = '0; ioWdata  = '0;
  endtask

  // Leaves the bench at the falling edge right after reset release, so the
  // next rising edge is the first IDLE arbitration.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) step();
    check("rst_state",  {30'd0, dbg_state}, 32'd0);
    check("rst_outs",   {26'd0, cpuReady, ioReady, memEn, memWriteEnable,
                         (memAddr != 0), (memWdata != 0)}, 32'd0);
    check("rst_rdata",  {cpuRdata, ioRdata}, 32'd0);
    exp_cpu_rd = '0;
    exp_io_rd  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int cyc_c, cyc_i, wr_cnt, nready, io_first_en;
    logic          prev_who;
    int            last_rdy[2];
    int            got;

    do_reset();

    // cpu read of 0x10 right after reset
    cpuReq = 1; cpuWe = 0; cpuAddr = 8'h10;
    sb_push(1'b0, 8'h10, 1'b0);
    step();
    check("rd_a1_en",    {31'd0, memEn}, 32'd1);
    check("rd_a1_addr",  {24'd0, memAddr}, 32'h10);
    check("rd_a1_we",    {31'd0, memWriteEnable}, 32'd0);
    check("rd_a1_state", {30'd0, dbg_state}, 32'd1);
    step();
    check("rd_a2_en",    {31'd0, memEn}, 32'd1);
    step();
    check("rd_done_en",  {31'd0, memEn}, 32'd0);
    check("rd_done_rdy", {30'd0, cpuReady, ioReady}, 32'b10);
    check("rd_done_dat", {16'd0, cpuRdata}, 32'hBEEF);
    check("rd_done_adr", {24'd0, memAddr}, 32'd0);
    cpuReq = 0;
    step();
    check("rd_after_rdy", {31'd0, cpuReady}, 32'd0);
    check("rd_after_st",  {30'd0, dbg_state}, 32'd0);

    // io write 0x22 <- 0x1234
    ioReq = 1; ioWe = 1; ioAddr = 8'h22; ioWdata = 16'h1234;
    sb_push(1'b1, 8'h22, 1'b1);
    wr_cnt = 0; nready = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (memWriteEnable && memAddr == 8'h22 && memWdata == 16'h1234) wr_cnt++;
      if (ioReady) begin
        nready++;
        check("wr_io_rdata", {16'd0, ioRdata}, 32'd0);
        ioReq = 0;
      end
    end
    check("wr_strobe_cycles", wr_cnt, 2);
    check("wr_ready_pulses",  nready, 1);
    check("wr_cpu_rdata_hold", {16'd0, cpuRdata}, 32'hBEEF);

    // simultaneous requests right after reset: cpu first, io 4 cycles later
    do_reset();
    cpuReq = 1; cpuWe = 0; cpuAddr = 8'h10;
    ioReq  = 1; ioWe  = 0; ioAddr  = 8'h22;
    sb_push(1'b0, 8'h10, 1'b0);
    sb_push(1'b1, 8'h22, 1'b0);
    cyc_c = -1; cyc_i = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (cpuReady) begin cyc_c = k; cpuReq = 0; end
      if (ioReady)  begin cyc_i = k; ioReq  = 0; end
    end
    check("tie_cpu_cycle", cyc_c, 3);
    check("tie_io_cycle",  cyc_i, 7);

    // both held for 8 grants: strict alternation, bounded wait
    cpuReq = 1; cpuWe = 0; cpuAddr = 8'h11;
    ioReq  = 1; ioWe  = 0; ioAddr  = 8'h23;
    for (int g = 0; g < 8; g++) sb_push(g[0], g[0] ? 8'h23 : 8'h11, 1'b0);
    got = 0; prev_who = 1'b1;
    last_rdy[0] = 0; last_rdy[1] = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (got < 8 && (cpuReady || ioReady)) begin
        check("rr_alternate", {31'd0, ioReady}, {31'd0, ~prev_who});
        prev_who = ioReady;
        check("rr_wait_le8", {31'd0, (k - last_rdy[ioReady]) <= 2*(LAT+2)}, 32'd1);
        last_rdy[ioReady] = k;
        got++;
        if (got == 8) begin cpuReq = 0; ioReq = 0; end
      end
    end
    check("rr_grants", got, 8);

    // reset pulse in the second ACCESS cycle of a cpu write
    cpuReq = 1; cpuWe = 1; cpuAddr = 8'h30; cpuWdata = 16'h5555;
    step();
    check("ab_a1_en", {31'd0, memEn}, 32'd1);
    step();
    check("ab_a2_we", {31'd0, memWriteEnable}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ab_async_en",  {30'd0, memEn, memWriteEnable}, 32'd0);
    check("ab_async_st",  {30'd0, dbg_state}, 32'd0);
    check("ab_no_ready",  {30'd0, cpuReady, ioReady}, 32'd0);
    idle_inputs();
    repeat (2) step();
    check("ab_hold_ready", {30'd0, cpuReady, ioReady}, 32'd0);
    exp_cpu_rd = '0;
    exp_io_rd  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check("ab_rdata_clr", {16'd0, cpuRdata}, 32'd0);
    cpuReq = 1; cpuWe = 0; cpuAddr = 8'h12;
    sb_push(1'b0, 8'h12, 1'b0);
    cyc_c = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (cpuReady) begin cyc_c = k; cpuReq = 0; end
    end
    check("ab_fresh_cycle", cyc_c, 3);

    // cpu drops Req in its first ACCESS cycle; pending io write follows
    cpuReq = 1; cpuWe = 0; cpuAddr = 8'h44;
    sb_push(1'b0, 8'h44, 1'b0);
    step();
    cpuReq = 0;
    ioReq = 1; ioWe = 1; ioAddr = 8'h50; ioWdata = 16'hABCD;
    sb_push(1'b1, 8'h50, 1'b1);
    cyc_c = -1; cyc_i = -1; io_first_en = -1; wr_cnt = 0;
    for (int k = 2; k <= 15; k++) begin
      step();
      if (cpuReady) cyc_c = k;
      if (memWriteEnable && memAddr == 8'h50 && memWdata == 16'hABCD) begin
        wr_cnt++;
        if (io_first_en < 0) io_first_en = k;
      end
      if (ioReady) begin cyc_i = k; ioReq = 0; end
    end
    check("drop_cpu_ready", cyc_c, 3);
    check("drop_io_access", io_first_en, 5);
    check("drop_io_wr_cnt", wr_cnt, 2);
    check("drop_io_ready",  cyc_i, 7);
    check("drop_cpu_rdata", {16'd0, cpuRdata}, {16'd0, mem_val(8'h44)});

    step();
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
